mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the CPU's single byte-addressed memory port between three requesters:
//  - program loader (writes only)
//  - instruction fetch (reads only)
//  - data load/store unit (reads and writes)
//  Sits between the cpu fetch/LSU logic and the memory instance. One transaction in flight at a time.
// PARAMETERS
//  ADDR_W   32  byte-address width
//  DATA_W   64  access width (8 bytes, little-endian, address passed through unmodified)
//  MEM_LAT  2   cycles from mem_en (read) to mem_rdata valid; legal range >= 1
// PORTS
//  clk        in   1       clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  halt       in   1       cpu halted; masks if_req
//  ld_req     in   1       loader write request
//  ld_addr    in   ADDR_W  loader address
//  ld_wdata   in   DATA_W  loader write data
//  ld_gnt     out  1       loader accepted (1-cycle pulse)
//  if_req     in   1       fetch read request
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       fetch accepted (1-cycle pulse)
//  if_rvalid  out  1       fetch read data valid (1-cycle pulse)
//  if_rdata   out  DATA_W  fetch read data, held until the next fetch rvalid
//  dm_req     in   1       data request
//  dm_we      in   1       1 = store, 0 = load
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_gnt     out  1       data accepted (1-cycle pulse)
//  dm_rvalid  out  1       load data valid (1-cycle pulse)
//  dm_rdata   out  DATA_W  load data, held until the next dm rvalid
//  mem_en     out  1       memory access strobe (1 cycle per transaction)
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after a read mem_en
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset
//  - All outputs 0; state = IDLE; rr_last = DM, so fetch wins the first fetch/data tie.
//  - Reset mid-transaction aborts it. No gnt/rvalid for it; mem_en = 0 the next cycle.
//  FSM
//  - IDLE: sample requests (if_req is masked by halt).
//    - If any request is present: latch winner, we, addr, wdata; go to ISSUE.
//  - ISSUE (1 cycle): mem_en = 1, mem_we / mem_addr / mem_wdata from latch; winner's gnt = 1.
//    - Write: next state IDLE.
//    - Read: next state WAIT with cnt = MEM_LAT - 1.
//  - WAIT: decrement cnt each cycle. At cnt == 0, capture mem_rdata (this is cycle ISSUE+MEM_LAT); go to RESP.
//  - RESP (1 cycle): owner's rvalid = 1, rdata = captured value; next state IDLE.
//  Latency
//  - Read: request sampled at cycle N -> gnt/mem_en at N+1 -> rvalid at N+MEM_LAT+2.
//  - Write: gnt/mem_en at N+1; back in IDLE at N+2.
//  Priority
//  - ld > {if, dm}. Fetch vs data is round-robin via rr_last, updated only when one of them is granted.
//  - A loader grant leaves rr_last unchanged.
//  Handshake rules
//  - Requesters hold req, addr and data stable until their gnt.
//  - The arbiter commits at the IDLE latch edge; a req dropped after that edge is still performed.
//  - Another req sampled while busy waits; no request is lost and none is served twice.
//  Outputs
//  - mem_addr / mem_wdata / mem_we are 0 whenever mem_en = 0.
//  - Only one gnt is high in any cycle; only one rvalid is high in any cycle.
//  Halt
//  - halt does not abort a fetch already latched.
//  - Loader and data traffic continue while halt = 1.
// TESTING  (MEM_LAT=2; stimulus applied at cycle 0)
//  1 Fetch read: if_req, addr 0x100; memory returns 0x1122334455667788.
//    -> if_gnt + mem_en at cycle 1, mem_addr = 0x100.
//    -> if_rvalid at cycle 4 with that data.
//  2 if_req and dm_req (load) held high, re-asserted after each gnt
//    -> grant order if, dm, if, dm; no gaps beyond the FSM latency.
//  3 ld_req, if_req and dm_req together
//    -> order ld (write), if, dm.
//    -> then ld_req again alongside if+dm: ld wins again.
//  4 dm store: addr 0x200, data 0xDEADBEEF
//    -> cycle 1: mem_en = 1, mem_we = 1, dm_gnt = 1; no dm_rvalid.
//    -> busy = 0 at cycle 2.
//  5 halt = 1 with if_req and dm_req
//    -> only dm is granted; if_gnt never asserts while halt = 1.
//  6 Reset asserted during WAIT of a fetch
//    -> next cycle all outputs 0, no if_rvalid.
//    -> after release, a new fetch completes with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory port between the program loader, instruction fetch
// and the data load/store unit, with one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
    typedef enum logic [1:0] {OwnLd, OwnIf, OwnDm} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rr_dm_q, rr_dm_d;  // 1: data unit was the last fetch/data winner
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              ld_gnt_q, ld_gnt_d;
    logic              if_gnt_q, if_gnt_d;
    logic              dm_gnt_q, dm_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;
    logic              if_req_m;

    assign if_req_m = if_req & ~halt;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        rr_dm_d     = rr_dm_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        ld_gnt_d    = 1'b0;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (ld_req) begin
                    owner_d     = OwnLd;
                    we_d        = 1'b1;
                    mem_addr_d  = ld_addr;
                    mem_wdata_d = ld_wdata;
                    ld_gnt_d    = 1'b1;
                    state_d     = StIssue;
                end else if (if_req_m && (!dm_req || rr_dm_q)) begin
                    owner_d    = OwnIf;
                    we_d       = 1'b0;
                    mem_addr_d = if_addr;
                    if_gnt_d   = 1'b1;
                    rr_dm_d    = 1'b0;
                    state_d    = StIssue;
                end else if (dm_req) begin
                    owner_d     = OwnDm;
                    we_d        = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    dm_gnt_d    = 1'b1;
                    rr_dm_d     = 1'b1;
                    state_d     = StIssue;
                end
                // Strobe and bus are registered so they appear together with the grant.
                if (state_d == StIssue) begin
                    mem_en_d = 1'b1;
                    mem_we_d = we_d;
                end
            end
            StIssue: begin
                if (we_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = CntW'(MEM_LAT - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (owner_q == OwnIf) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        dm_rdata_d  = mem_rdata;
                        dm_rvalid_d = 1'b1;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnLd;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            rr_dm_q     <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_gnt_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            rr_dm_q     <= rr_dm_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_gnt_q    <= ld_gnt_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ld_gnt    = ld_gnt_q;
    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

endmodule
